// File: rtl/adain_pkg.sv
// Shared types and defaults for the axis_adain replay feeder.
// Side length decode is kept here so every user sees the same clamp.
package adain_pkg;
    localparam int WIDTH_DEF = 48;
    localparam int N_MAX_DEF = 128;
    localparam int AW_DEF    = 14;

    typedef enum logic [1:0] {IDLE, LOAD_YB, LOAD_PIX, EMIT} state_e;
    typedef enum logic [1:0] {E_YS, E_YB, E_P1, E_P2} phase_e;

    // N = 4<<sel, clamped to n_max for out-of-range selects
    function automatic int n_from_sel(input logic [2:0] sel, input int n_max);
        int n;
        n = 4 << sel;
        if (sel > 3'd5 || n > n_max) begin
            n = n_max;
        end
        return n;
    endfunction
endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame buffer: one write port, one read port with 1-cycle registered output.
// No reset on the array or read register so it maps onto block RAM.
module frame_ram #(
    parameter int WIDTH = 48,
    parameter int AW    = 14
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [2**AW];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/axis_adain_replay.sv
// Buffers one channel frame (ys, yb, N*N pixels) and replays it as ys, yb, pass 1, pass 2.
// Output goes through a 2-entry skid fed by a prefetching RAM reader; first beat the cycle after the last pixel.
module axis_adain_replay
    import adain_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N_MAX = N_MAX_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [2:0]       gpio_N_sel,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             busy,
    output logic             err_len
);
    state_e           state_q, state_d;
    phase_e           phase_q, phase_d;
    logic [AW-1:0]    cnt_q, cnt_d, rd_idx_q, rd_idx_d, last_q, last_d;
    logic [WIDTH-1:0] ys_q, ys_d, yb_q, yb_d;
    logic             err_q, err_d, done_q, done_d;
    logic             rd_pend_q, rd_pend_d, rd_last_q, rd_last_d;
    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
    logic             l0_q, l0_d, l1_q, l1_d;

    logic             s_fire, pop, ram_we, issue, push_vld, push_last;
    logic [WIDTH-1:0] push_dat, ram_rdata;
    logic [1:0]       base, occ_pop;
    int               n_lat;

    frame_ram #(.WIDTH(WIDTH), .AW(AW)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (cnt_q),
        .wdata_i (s_axis_tdata),
        .re_i    (issue),
        .raddr_i (rd_idx_q),
        .rdata_o (ram_rdata)
    );

    assign s_axis_tready = (state_q != EMIT);
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign pop           = (occ_q != 2'd0) && m_axis_tready;
    // Skid slots spoken for at the end of this cycle, before any new read is issued
    assign base          = occ_q - {1'b0, pop} + {1'b0, rd_pend_q};
    assign occ_pop       = occ_q - {1'b0, pop};

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        rd_idx_d  = rd_idx_q;
        last_d    = last_q;
        ys_d      = ys_q;
        yb_d      = yb_q;
        err_d     = err_q;
        done_d    = done_q;
        rd_pend_d = 1'b0;
        rd_last_d = rd_last_q;
        occ_d     = occ_q;
        d0_d      = d0_q;
        l0_d      = l0_q;
        d1_d      = d1_q;
        l1_d      = l1_q;
        ram_we    = 1'b0;
        issue     = 1'b0;
        push_vld  = rd_pend_q;
        push_dat  = ram_rdata;
        push_last = rd_last_q;
        n_lat     = n_from_sel(gpio_N_sel, N_MAX);

        case (state_q)
            IDLE: begin
                if (s_fire) begin
                    if (s_axis_tlast) begin
                        err_d = 1'b1;
                    end else begin
                        ys_d    = s_axis_tdata;
                        last_d  = AW'(n_lat * n_lat - 1);
                        state_d = LOAD_YB;
                    end
                end
            end
            LOAD_YB: begin
                if (s_fire) begin
                    if (s_axis_tlast) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        yb_d    = s_axis_tdata;
                        cnt_d   = '0;
                        state_d = LOAD_PIX;
                    end
                end
            end
            LOAD_PIX: begin
                if (s_fire) begin
                    ram_we = 1'b1;
                    if (cnt_q == last_q) begin
                        err_d     = err_q | ~s_axis_tlast;
                        state_d   = EMIT;
                        phase_d   = E_YB;
                        rd_idx_d  = '0;
                        done_d    = 1'b0;
                        push_vld  = 1'b1;
                        push_dat  = ys_q;
                        push_last = 1'b0;
                    end else if (s_axis_tlast) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            EMIT: begin
                case (phase_q)
                    E_YB: begin
                        // yb and the first RAM read leave together so pass 1 follows with no bubble
                        if (base == 2'd0) begin
                            push_vld  = 1'b1;
                            push_dat  = yb_q;
                            push_last = 1'b0;
                            issue     = 1'b1;
                            phase_d   = E_P1;
                        end
                    end
                    E_P1, E_P2: begin
                        issue = !done_q && (base != 2'd2);
                    end
                    default: ;
                endcase
                if (issue) begin
                    rd_pend_d = 1'b1;
                    rd_last_d = (rd_idx_q == last_q);
                    if (rd_idx_q == last_q) begin
                        rd_idx_d = '0;
                        if (phase_q == E_P2) begin
                            done_d = 1'b1;
                        end else begin
                            phase_d = E_P2;
                        end
                    end else begin
                        rd_idx_d = rd_idx_q + AW'(1);
                    end
                end
                if (pop && l0_q && done_q) begin
                    state_d = IDLE;
                    phase_d = E_YS;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop && occ_q == 2'd2) begin
            d0_d = d1_q;
            l0_d = l1_q;
        end
        if (push_vld) begin
            if (occ_pop == 2'd0) begin
                d0_d = push_dat;
                l0_d = push_last;
            end else begin
                d1_d = push_dat;
                l1_d = push_last;
            end
        end
        occ_d = occ_pop + {1'b0, push_vld};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            phase_q   <= E_YS;
            cnt_q     <= '0;
            rd_idx_q  <= '0;
            last_q    <= '0;
            ys_q      <= '0;
            yb_q      <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_last_q <= 1'b0;
            occ_q     <= 2'd0;
            d0_q      <= '0;
            l0_q      <= 1'b0;
            d1_q      <= '0;
            l1_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            rd_idx_q  <= rd_idx_d;
            last_q    <= last_d;
            ys_q      <= ys_d;
            yb_q      <= yb_d;
            err_q     <= err_d;
            done_q    <= done_d;
            rd_pend_q <= rd_pend_d;
            rd_last_q <= rd_last_d;
            occ_q     <= occ_d;
            d0_q      <= d0_d;
            l0_q      <= l0_d;
            d1_q      <= d1_d;
            l1_q      <= l1_d;
        end
    end

    assign m_axis_tvalid = (occ_q != 2'd0);
    assign m_axis_tdata  = d0_q;
    assign m_axis_tlast  = l0_q;
    assign busy          = (state_q != IDLE);
    assign err_len       = err_q;
endmodule

// File: tb/tb_axis_adain_replay.sv
// Directed bench for axis_adain_replay: frame load, two-pass replay, stalls, length errors and reset.
module tb_axis_adain_replay;
    localparam int W = 48;

    logic         clk;
    logic         rstn;
    logic [2:0]   gpio_N_sel;
    logic [W-1:0] s_tdata;
    logic         s_tvalid, s_tready, s_tlast;
    logic [W-1:0] m_tdata;
    logic         m_tvalid, m_tready, m_tlast;
    logic         busy, err_len;

    axis_adain_replay dut (
        .clk           (clk),
        .rstn          (rstn),
        .gpio_N_sel    (gpio_N_sel),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .busy          (busy),
        .err_len       (err_len)
    );

    int cyc      = 0;
    int n_vec    = 0;
    int n_err    = 0;
    int rdy_mode = 0;
    int src_cyc  = 0;
    int stab_err = 0;

    logic [W-1:0] pix[$];
    logic [W-1:0] mon_dat[$];
    logic         mon_last[$];
    int           mon_cyc[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) m_tready = 1'b1;
            else m_tready = ((cyc / 2) % 2) == 0;
        end
    end

    // Output monitor: records accepted beats and flags any change while stalled
    initial begin : mon
        logic         pend;
        logic [W-1:0] pd;
        logic         pl;
        pend = 1'b0;
        pd   = '0;
        pl   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                pend = 1'b0;
            end else begin
                if (pend && !(m_tvalid && m_tdata == pd && m_tlast == pl)) stab_err++;
                if (m_tvalid) begin
                    pend = !m_tready;
                    pd   = m_tdata;
                    pl   = m_tlast;
                    if (m_tready) begin
                        mon_dat.push_back(m_tdata);
                        mon_last.push_back(m_tlast);
                        mon_cyc.push_back(cyc);
                    end
                end else begin
                    pend = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is taken
    task automatic send_beat(input logic [W-1:0] d, input logic l, input bit gap);
        int t;
        if (gap) begin
            s_tvalid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!s_tready && t < 2000);
        if (!s_tready) check("src_timeout", 64'(t), 64'(0));
        src_cyc = cyc;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [2:0] sel, input logic [W-1:0] ys, input logic [W-1:0] yb,
                              input int npix, input int last_at, input bit gap, input bit chg);
        gpio_N_sel = sel;
        send_beat(ys, 1'b0, gap);
        if (chg) gpio_N_sel = 3'd5;
        send_beat(yb, 1'b0, gap);
        for (int i = 0; i < npix; i++) send_beat(pix[i], (i == last_at), gap);
        gpio_N_sel = sel;
    endtask

    task automatic check_emit(input string tag, input int nn, input logic [W-1:0] ys,
                              input logic [W-1:0] yb, input int budget, input bit timing);
        int t;
        int bad_d;
        int bad_l;
        logic [W-1:0] ed;
        logic el;
        t = 0;
        while (mon_dat.size() < 2 * nn + 2 && t < budget) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check({tag, "_count"}, 64'(mon_dat.size()), 64'(2 * nn + 2));
        bad_d = 0;
        bad_l = 0;
        for (int i = 0; i < mon_dat.size() && i < 2 * nn + 2; i++) begin
            if (i == 0) ed = ys;
            else if (i == 1) ed = yb;
            else ed = pix[(i - 2) % nn];
            el = (i == nn + 1) || (i == 2 * nn + 1);
            if (mon_dat[i] !== ed) bad_d++;
            if (mon_last[i] !== el) bad_l++;
        end
        check({tag, "_bad_data"}, 64'(bad_d), 64'(0));
        check({tag, "_bad_tlast"}, 64'(bad_l), 64'(0));
        check({tag, "_stall_stable"}, 64'(stab_err), 64'(0));
        check({tag, "_busy_after"}, 64'(busy), 64'(0));
        if (timing && mon_dat.size() == 2 * nn + 2) begin
            check({tag, "_first_latency"}, 64'(mon_cyc[0] - src_cyc), 64'(1));
            check({tag, "_span"}, 64'(mon_cyc[2 * nn + 1] - mon_cyc[0]), 64'(2 * nn + 1));
        end
        @(posedge clk);
        #1;
        mon_dat.delete();
        mon_last.delete();
        mon_cyc.delete();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        int t;
        rstn       = 1'b0;
        gpio_N_sel = 3'd0;
        s_tdata    = '0;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", 64'(s_tready), 64'(1));
        check("rst_tvalid", 64'(m_tvalid), 64'(0));
        check("rst_tlast", 64'(m_tlast), 64'(0));
        check("rst_tdata", 64'(m_tdata), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_err", 64'(err_len), 64'(0));
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // 1: N=4, full rate both sides
        pix.delete();
        for (int i = 0; i < 16; i++) pix.push_back(W'(i + 1) << 16);
        send_frame(3'd0, 48'h000000010000, 48'h0, 16, 15, 1'b0, 1'b0);
        check("t1_busy_emit", 64'(busy), 64'(1));
        check("t1_tready_emit", 64'(s_tready), 64'(0));
        check_emit("t1", 16, 48'h000000010000, 48'h0, 200, 1'b1);
        check("t1_err", 64'(err_len), 64'(0));

        // 2: same frame, valid gaps, ready toggling, select changed after latch
        rdy_mode = 1;
        send_frame(3'd0, 48'h000000010000, 48'h0, 16, 15, 1'b1, 1'b1);
        check_emit("t2", 16, 48'h000000010000, 48'h0, 500, 1'b0);
        rdy_mode = 0;

        // 3: N=128 ramp
        pix.delete();
        for (int i = 0; i < 16384; i++) pix.push_back(W'(i));
        send_frame(3'd5, 48'h123456789ABC, 48'hFEDCBA987654, 16384, 16383, 1'b0, 1'b0);
        check_emit("t3", 16384, 48'h123456789ABC, 48'hFEDCBA987654, 40000, 1'b1);

        // 4: early tlast on pixel 10, then a good frame
        pix.delete();
        for (int i = 0; i < 16; i++) pix.push_back(W'(i + 1) << 16);
        send_frame(3'd0, 48'h000000010000, 48'h0, 10, 9, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("t4_err", 64'(err_len), 64'(1));
        check("t4_busy", 64'(busy), 64'(0));
        check("t4_tready", 64'(s_tready), 64'(1));
        check("t4_no_output", 64'(mon_dat.size()), 64'(0));
        send_frame(3'd0, 48'h000000010000, 48'h0, 16, 15, 1'b0, 1'b0);
        check_emit("t4_good", 16, 48'h000000010000, 48'h0, 200, 1'b0);
        check("t4_err_sticky", 64'(err_len), 64'(1));

        // 6: reset in the middle of pass 1
        pix.delete();
        for (int i = 0; i < 16; i++) pix.push_back(W'(48'h100 + i));
        send_frame(3'd0, 48'hAAAA0000, 48'h55550000, 16, 15, 1'b0, 1'b0);
        t = 0;
        while (mon_dat.size() < 6 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("t6_rst_tvalid", 64'(m_tvalid), 64'(0));
        check("t6_rst_tdata", 64'(m_tdata), 64'(0));
        check("t6_rst_tlast", 64'(m_tlast), 64'(0));
        check("t6_rst_busy", 64'(busy), 64'(0));
        check("t6_rst_err", 64'(err_len), 64'(0));
        check("t6_rst_tready", 64'(s_tready), 64'(1));
        rstn = 1'b1;
        mon_dat.delete();
        mon_last.delete();
        mon_cyc.delete();
        @(posedge clk);
        #1;
        send_frame(3'd0, 48'hBBBB0000, 48'hCCCC0000, 16, 15, 1'b0, 1'b0);
        check_emit("t6_after", 16, 48'hBBBB0000, 48'hCCCC0000, 200, 1'b1);

        // tlast on the ys beat
        send_beat(48'h7, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("tys_err", 64'(err_len), 64'(1));
        check("tys_busy", 64'(busy), 64'(0));
        check("tys_no_output", 64'(mon_dat.size()), 64'(0));
        do_reset();

        // 5: 16 pixels with no tlast
        send_frame(3'd0, 48'hDDDD0000, 48'hEEEE0000, 16, -1, 1'b0, 1'b0);
        check_emit("t5", 16, 48'hDDDD0000, 48'hEEEE0000, 200, 1'b1);
        check("t5_err", 64'(err_len), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
